// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: state encodings, opcodes,
// datapath select encodings and fault codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_FAULT  = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_TIMEOUT = 2'b01;
  localparam logic [1:0] FC_ILLEGAL = 2'b10;

  // States in which the controller waits on mem_ready
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_timeout_counter.sv
// Memory wait counter: counts stalled cycles and flags expiry on the last
// allowed cycle unless memory completes in that same cycle.
module mc_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic count,
  input  logic mem_ready,
  output logic expired
);

  logic [7:0] r_cnt;

  // Stall counter; clear has priority over counting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (count && !mem_ready) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign expired = count && !mem_ready && (r_cnt == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style controller (Moore FSM) with memory-wait timeout and
// illegal-opcode fault. Optional jump support is enabled by defining MC_JUMP_EN.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic       pc_en,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic [3:0] state_dbg,
  output logic       fault,
  output logic [1:0] fault_code
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_fault_code;
  logic [1:0] w_next_code;
  logic       w_expired;
  logic       w_clear;
  logic       w_count;

  // Any state change restarts the counter, so each wait state is entered at 0
  assign w_count = is_wait_state(r_state);
  assign w_clear = (w_next != r_state);

  mc_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (w_clear),
    .count     (w_count),
    .mem_ready (mem_ready),
    .expired   (w_expired)
  );

  // Next-state and fault-code selection
  always_comb begin
    w_next      = r_state;
    w_next_code = r_fault_code;
    case (r_state)
      S_FETCH: begin
        if (mem_ready)      w_next = S_DECODE;
        else if (w_expired) begin
          w_next      = S_FAULT;
          w_next_code = FC_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
`ifdef MC_JUMP_EN
          OP_J:         w_next = S_JUMP;
`endif
          default: begin
            w_next      = S_FAULT;
            w_next_code = FC_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      w_next = S_MEMRD;
        else if (opcode == OP_SW) w_next = S_MEMWR;
        else begin
          w_next      = S_FAULT;
          w_next_code = FC_ILLEGAL;
        end
      end
      S_MEMRD: begin
        if (mem_ready)      w_next = S_MEMWB;
        else if (w_expired) begin
          w_next      = S_FAULT;
          w_next_code = FC_TIMEOUT;
        end
      end
      S_MEMWR: begin
        if (mem_ready)      w_next = S_FETCH;
        else if (w_expired) begin
          w_next      = S_FAULT;
          w_next_code = FC_TIMEOUT;
        end
      end
      S_MEMWB:  w_next = S_FETCH;
      S_EXEC:   w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_ADDIEX: w_next = S_ADDIWB;
      S_ADDIWB: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_FAULT:  w_next = S_FAULT;
      default:  w_next = S_FETCH;
    endcase
  end

  // State and fault-code registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_FETCH;
      r_fault_code <= FC_NONE;
    end else begin
      r_state      <= w_next;
      r_fault_code <= w_next_code;
    end
  end

  // State-decoded outputs; the whole set is gated low while reset is held
  // because the reset state (FETCH) would otherwise assert mem_read.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    pc_en      = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALUOP_ADD;
    pc_src     = PC_SRC_ALU;
    fault      = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PC_SRC_ALUOUT;
        pc_en     = zero;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: reg_write = 1'b1;
`ifdef MC_JUMP_EN
      S_JUMP: begin
        pc_src = PC_SRC_JUMP;
        pc_en  = 1'b1;
      end
`endif
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
    if (!reset_n) begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      pc_en      = 1'b0;
      alu_src_b  = '0;
      alu_op     = '0;
      pc_src     = '0;
      fault      = 1'b0;
    end
  end

  assign state_dbg  = reset_n ? r_state : S_FETCH;
  assign fault_code = reset_n ? r_fault_code : FC_NONE;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller (default build,
// jump support disabled, TIMEOUT_CYCLES=4).
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a, pc_en;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state_dbg;
  logic       fault;
  logic [1:0] fault_code;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_controller #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .iord       (iord),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .pc_en      (pc_en),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .state_dbg  (state_dbg),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  // Control vector: {mr,mw,iord,irw,rdst,m2r,rw,asa,pce,asb[1:0],aop[1:0],pcs[1:0]}
  localparam logic [14:0] C_ZERO     = 15'b000000000_00_00_00;
  localparam logic [14:0] C_FETCH_R  = 15'b100100001_01_00_00;
  localparam logic [14:0] C_FETCH_W  = 15'b100000000_01_00_00;
  localparam logic [14:0] C_DECODE   = 15'b000000000_11_00_00;
  localparam logic [14:0] C_MEMADR   = 15'b000000010_10_00_00;
  localparam logic [14:0] C_MEMRD    = 15'b101000000_00_00_00;
  localparam logic [14:0] C_MEMWB    = 15'b000001100_00_00_00;
  localparam logic [14:0] C_MEMWR    = 15'b011000000_00_00_00;
  localparam logic [14:0] C_EXEC     = 15'b000000010_00_10_00;
  localparam logic [14:0] C_ALUWB    = 15'b000010100_00_00_00;
  localparam logic [14:0] C_BRANCH_T = 15'b000000011_00_01_01;
  localparam logic [14:0] C_BRANCH_N = 15'b000000010_00_01_01;
  localparam logic [14:0] C_ADDIWB   = 15'b000000100_00_00_00;

  logic [14:0] w_ctl;
  assign w_ctl = {mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg,
                  reg_write, alu_src_a, pc_en, alu_src_b, alu_op, pc_src};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] st, input logic [14:0] ctl,
                     input logic flt, input logic [1:0] code);
    check({tag, ".state"}, {12'd0, state_dbg}, {12'd0, st});
    check({tag, ".ctl"}, {1'b0, w_ctl}, {1'b0, ctl});
    check({tag, ".fault"}, {13'd0, fault, fault_code}, {13'd0, flt, code});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    opcode    = 6'b100011;
    zero      = 1'b0;
    mem_ready = 1'b1;
    #3;
    chk("reset", 4'd0, C_ZERO, 1'b0, 2'b00);
    release_reset();

    // lw, zero-wait memory: 0,1,2,3,4,0
    chk("lw.fetch", 4'd0, C_FETCH_R, 1'b0, 2'b00);
    step(); chk("lw.decode", 4'd1, C_DECODE, 1'b0, 2'b00);
    step(); chk("lw.memadr", 4'd2, C_MEMADR, 1'b0, 2'b00);
    step(); chk("lw.memrd", 4'd3, C_MEMRD, 1'b0, 2'b00);
    step(); chk("lw.memwb", 4'd4, C_MEMWB, 1'b0, 2'b00);
    step(); chk("lw.done", 4'd0, C_FETCH_R, 1'b0, 2'b00);

    // sw with 3 stall cycles; completion lands on the last allowed cycle
    opcode = 6'b101011;
    step(); chk("sw.decode", 4'd1, C_DECODE, 1'b0, 2'b00);
    step(); chk("sw.memadr", 4'd2, C_MEMADR, 1'b0, 2'b00);
    step(); mem_ready = 1'b0; #1;
    chk("sw.memwr0", 4'd5, C_MEMWR, 1'b0, 2'b00);
    step(); chk("sw.memwr1", 4'd5, C_MEMWR, 1'b0, 2'b00);
    step(); chk("sw.memwr2", 4'd5, C_MEMWR, 1'b0, 2'b00);
    step(); mem_ready = 1'b1; #1;
    chk("sw.memwr3", 4'd5, C_MEMWR, 1'b0, 2'b00);
    step(); chk("sw.done", 4'd0, C_FETCH_R, 1'b0, 2'b00);

    // R-type
    opcode = 6'b000000;
    step(); chk("r.decode", 4'd1, C_DECODE, 1'b0, 2'b00);
    step(); chk("r.exec", 4'd6, C_EXEC, 1'b0, 2'b00);
    step(); chk("r.aluwb", 4'd7, C_ALUWB, 1'b0, 2'b00);
    step(); chk("r.done", 4'd0, C_FETCH_R, 1'b0, 2'b00);

    // addi
    opcode = 6'b001000;
    step(); chk("addi.decode", 4'd1, C_DECODE, 1'b0, 2'b00);
    step(); chk("addi.ex", 4'd9, C_MEMADR, 1'b0, 2'b00);
    step(); chk("addi.wb", 4'd10, C_ADDIWB, 1'b0, 2'b00);
    step(); chk("addi.done", 4'd0, C_FETCH_R, 1'b0, 2'b00);

    // beq taken then not taken
    opcode = 6'b000100;
    zero   = 1'b1;
    step(); chk("beq.decode", 4'd1, C_DECODE, 1'b0, 2'b00);
    step(); chk("beq.taken", 4'd8, C_BRANCH_T, 1'b0, 2'b00);
    zero = 1'b0; #1;
    chk("beq.nottaken", 4'd8, C_BRANCH_N, 1'b0, 2'b00);
    step(); chk("beq.done", 4'd0, C_FETCH_R, 1'b0, 2'b00);

    // lw aborted by reset during a stalled MEMRD
    opcode = 6'b100011;
    step(); step();
    step(); mem_ready = 1'b0; #1;
    chk("abort.memrd0", 4'd3, C_MEMRD, 1'b0, 2'b00);
    step(); chk("abort.memrd1", 4'd3, C_MEMRD, 1'b0, 2'b00);
    reset_n = 1'b0; #1;
    chk("abort.inreset", 4'd0, C_ZERO, 1'b0, 2'b00);
    release_reset();
    chk("abort.fetch", 4'd0, C_FETCH_W, 1'b0, 2'b00);

    // FETCH timeout (counter restarted by the reset above): fault on 4th cycle
    step(); chk("to.w1", 4'd0, C_FETCH_W, 1'b0, 2'b00);
    step(); chk("to.w2", 4'd0, C_FETCH_W, 1'b0, 2'b00);
    step(); chk("to.w3", 4'd0, C_FETCH_W, 1'b0, 2'b00);
    step(); chk("to.fault", 4'd15, C_ZERO, 1'b1, 2'b01);
    mem_ready = 1'b1;
    step(); step(); chk("to.held", 4'd15, C_ZERO, 1'b1, 2'b01);
    reset_n = 1'b0; #1;
    chk("to.reset", 4'd0, C_ZERO, 1'b0, 2'b00);
    release_reset();

    // Illegal opcode 111111
    opcode = 6'b111111;
    step(); chk("ill.decode", 4'd1, C_DECODE, 1'b0, 2'b00);
    step(); chk("ill.fault", 4'd15, C_ZERO, 1'b1, 2'b10);
    reset_n = 1'b0; #1;
    release_reset();

    // Jump opcode with jump support disabled
    opcode = 6'b000010;
    step(); chk("j.decode", 4'd1, C_DECODE, 1'b0, 2'b00);
    step(); chk("j.fault", 4'd15, C_ZERO, 1'b1, 2'b10);
    step(); chk("j.held", 4'd15, C_ZERO, 1'b1, 2'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, which is the maximum number of cycles spent waiting for mem_ready before a fault (range 2..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port opcode, input, 6 bits: instruction-register bits [31:26].
REQ-005 SHALL have port zero, input, 1 bit: the ALU zero flag.
REQ-006 SHALL have port mem_ready, input, 1 bit: memory has completed the current read or write this cycle.
REQ-007 SHALL have outputs mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a and pc_en, each 1 bit: datapath enables and selects.
REQ-008 SHALL have outputs alu_src_b, alu_op and pc_src, each 2 bits: datapath mux selects and the ALU-decoder class.
REQ-009 SHALL have output state_dbg, 4 bits: the current state encoding.
REQ-010 SHALL have output fault, 1 bit, and output fault_code, 2 bits: 01 = timeout, 10 = illegal opcode.

Function
REQ-011 SHALL implement a Moore FSM with these encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, FAULT 15.
REQ-012 SHALL drive these FETCH outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write=pc_en=mem_ready. The FSM stays in FETCH while mem_ready=0 and goes to DECODE on mem_ready=1.
REQ-013 SHALL drive these DECODE outputs: alu_src_a=0, alu_src_b=11, alu_op=00.
REQ-014 SHALL take these DECODE transitions by opcode: 100011/101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP. Any other opcode -> FAULT with fault_code=10.
REQ-015 SHALL drive these MEMADR outputs: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEMRD for 100011, MEMWR for 101011.
REQ-016 SHALL drive these MEMRD outputs: mem_read=1, iord=1. On mem_ready -> MEMWB, otherwise hold.
REQ-017 SHALL drive these MEMWB outputs: reg_write=1, reg_dst=0, mem_to_reg=1. Next state is FETCH.
REQ-018 SHALL drive these MEMWR outputs: mem_write=1, iord=1. On mem_ready -> FETCH, otherwise hold.
REQ-019 SHALL drive these EXEC outputs: alu_src_a=1, alu_src_b=00, alu_op=10, then go to ALUWB.
REQ-020 SHALL drive these ALUWB outputs: reg_write=1, reg_dst=1, mem_to_reg=0, then go to FETCH.
REQ-021 SHALL drive these BRANCH outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero. Next state is FETCH.
REQ-022 SHALL drive these ADDIEX outputs: alu_src_a=1, alu_src_b=10, alu_op=00, then go to ADDIWB.
REQ-023 SHALL drive these ADDIWB outputs: reg_write=1, reg_dst=0, mem_to_reg=0, then go to FETCH.
REQ-024 SHALL drive these JUMP outputs: pc_src=10, pc_en=1. Next state is FETCH.
REQ-025 SHALL drive 0 on every output not listed for the current state.
REQ-026 SHALL clear the wait counter on entry to FETCH, MEMRD or MEMWR. The counter increments each cycle in those states while mem_ready=0.
REQ-027 SHALL go to FAULT with fault_code=01 when the counter equals TIMEOUT_CYCLES-1 and mem_ready=0. If mem_ready=1 in that same cycle, the completion wins and no fault is raised.
REQ-028 SHALL make FAULT absorbing: fault=1, fault_code held, all datapath outputs 0, exit only by reset.
REQ-029 SHALL make the latencies in cycles, with zero-wait memory: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-030 SHALL, while reset_n=0, immediately force state=FETCH, counter=0, fault=0, fault_code=00, and every other output to 0 (all enables gated).
REQ-031 SHALL abort any in-flight memory access when reset is asserted mid-operation. The first cycle after release is a fresh FETCH.

Configuration
REQ-032 SHALL provide macro MC_JUMP_EN. When defined, opcode 000010 is decoded to the JUMP state.
REQ-033 SHALL, when MC_JUMP_EN is undefined, treat 000010 as an illegal opcode (FAULT, fault_code=10), never enter JUMP, and never drive pc_src=10.

Structure
REQ-034 SHALL put the state encodings, opcode constants, alu_op/pc_src encodings and fault codes in shared package mc_pkg.
REQ-035 SHALL implement the wait counter and timeout compare in sub-module mc_timeout_counter, with inputs clear, count and mem_ready, output expired, and parameter TIMEOUT_CYCLES.

Verification
REQ-036 SHALL cover lw with mem_ready tied 1: state sequence 0,1,2,3,4,0; reg_write=1 only in state 4 with mem_to_reg=1.
REQ-037 SHALL cover beq with zero=1, then with zero=0: pc_en=1 with pc_src=01 in BRANCH, then pc_en=0 in BRANCH.
REQ-038 SHALL cover sw with mem_ready low for 3 cycles: MEMWR held 4 cycles with mem_write=1 and iord=1, then FETCH.
REQ-039 SHALL cover a timeout with TIMEOUT_CYCLES=4 and mem_ready=0 in FETCH: FAULT after 4 cycles, fault=1, fault_code=01, held until reset_n=0.
REQ-040 SHALL cover opcode 111111 in DECODE, and 000010 with MC_JUMP_EN undefined: FAULT, fault_code=10.
REQ-041 SHALL cover reset_n pulsed low during MEMRD: outputs 0 immediately, FETCH on release, counter=0.
